board_ram_arbiter: RTL and testbench

Shares the single-port board-cell RAM (one 4-bit piece kind per cell, 10x20 board) between the VGA display read path and the game-logic write path. Display reads have absolute priority and fixed one-cycle latency, so pixel fetch never stalls. Game-logic cell writes queue in a small FIFO and drain into RAM on cycles the display leaves free. A board-clear sequencer sweeps the RAM to zero on request. Sits between the game core, the display pipeline (which supplies tetris_x/tetris_y-style cell coordinates), and the board RAM.

---
 rtl/board_ram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_board_ram_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single-port board-cell RAM between display
// reads (absolute priority, one-cycle latency), a board-clear sweep, and a
// small FIFO of game-logic cell writes. Optional macro BOARD_ARB_HWM_EN
// enables the fifo_hwm occupancy high-water mark; otherwise fifo_hwm is 0.
module board_ram_arbiter #(
    parameter int DEPTH = 4,
    parameter int COLS  = 10,
    parameter int ROWS  = 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     disp_req,
    input  logic [4:0]               disp_x,
    input  logic [4:0]               disp_y,
    output logic                     disp_valid,
    output logic [3:0]               disp_kind,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [4:0]               wr_x,
    input  logic [4:0]               wr_y,
    input  logic [3:0]               wr_kind,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [7:0]               ram_addr,
    output logic [3:0]               ram_wdata,
    input  logic [3:0]               ram_rdata,
    output logic [$clog2(DEPTH):0]   fifo_hwm
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int CELLS = COLS * ROWS;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    function automatic logic in_range(input logic [4:0] x, input logic [4:0] y);
        return (int'(x) < COLS) && (int'(y) < ROWS);
    endfunction

    function automatic logic [7:0] cell_addr(input logic [4:0] x, input logic [4:0] y);
        return 8'(int'(y) * COLS + int'(x));
    endfunction

    logic [0:0]    r_state;
    logic [7:0]    r_clr_addr;
    logic [4:0]    r_fx [DEPTH];
    logic [4:0]    r_fy [DEPTH];
    logic [3:0]    r_fk [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          r_disp_valid;
    logic          r_disp_hit;

    logic          w_disp_inr;
    logic          w_head_inr;
    logic          w_start_clear;
    logic          w_push;
    logic          w_pop;
    logic          w_clr_step;
    logic [PW-1:0] w_wr_idx;
    logic [CW-1:0] w_count_next;

    assign w_disp_inr    = disp_req && in_range(disp_x, disp_y);
    assign w_head_inr    = in_range(r_fx[r_rd], r_fy[r_rd]);
    assign w_start_clear = (r_state == S_IDLE) && clear_req;
    assign wr_ready      = (r_count != CW'(DEPTH)) && reset_n;
    assign w_push        = wr_valid && wr_ready;
    // A write accepted in the clear_req cycle lands in slot 0 of the flushed FIFO.
    assign w_wr_idx      = w_start_clear ? '0 : r_wr;
    assign clear_busy    = (r_state == S_CLEAR);
    assign disp_valid    = r_disp_valid;
    // Select is registered; the data is the RAM's own registered output.
    assign disp_kind     = r_disp_hit ? ram_rdata : '0;

    // Per-cycle RAM slot: display read, then clear sweep, then FIFO head.
    always_comb begin
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        w_pop      = 1'b0;
        w_clr_step = 1'b0;
        if (reset_n) begin
            if (w_disp_inr) begin
                ram_en   = 1'b1;
                ram_addr = cell_addr(disp_x, disp_y);
            end else if (r_state == S_CLEAR) begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = r_clr_addr;
                w_clr_step = 1'b1;
            end else if (!clear_req && (r_count != '0)) begin
                // Out-of-range entries are popped without touching the RAM.
                w_pop = 1'b1;
                if (w_head_inr) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = cell_addr(r_fx[r_rd], r_fy[r_rd]);
                    ram_wdata = r_fk[r_rd];
                end
            end
        end
    end

    // Next FIFO occupancy, including the flush on clear start.
    always_comb begin
        if (w_start_clear) begin
            w_count_next = w_push ? CW'(1) : '0;
        end else begin
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Clear-sweep state machine and address counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_clr_addr <= '0;
        end else if (w_start_clear) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else if (w_clr_step) begin
            if (r_clr_addr == 8'(CELLS - 1)) begin
                r_state <= S_IDLE;
            end
            r_clr_addr <= r_clr_addr + 8'd1;
        end
    end

    // FIFO pointers and occupancy; clear start discards pending entries.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_start_clear) begin
                r_rd <= '0;
                r_wr <= w_push ? PW'(1) : '0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + PW'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + PW'(1);
                end
            end
        end
    end

    // FIFO storage write on handshake.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fx[w_wr_idx] <= wr_x;
            r_fy[w_wr_idx] <= wr_y;
            r_fk[w_wr_idx] <= wr_kind;
        end
    end

    // Display response: pulse one cycle after every request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_disp_valid <= 1'b0;
            r_disp_hit   <= 1'b0;
        end else begin
            r_disp_valid <= disp_req;
            r_disp_hit   <= w_disp_inr;
        end
    end

`ifdef BOARD_ARB_HWM_EN
    logic [CW-1:0] r_hwm;

    // Track peak occupancy after each enqueue; bounded by DEPTH by construction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hwm <= '0;
        end else if (w_push && (w_count_next > r_hwm)) begin
            r_hwm <= w_count_next;
        end
    end

    assign fifo_hwm = r_hwm;
`else
    assign fifo_hwm = '0;
`endif

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: board RAM model plus a queue-based reference of the
// arbiter's slot rules; display results are scoreboarded one cycle later.
module tb_board_ram_arbiter;
    localparam int DEPTH = 4;
    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int CELLS = COLS * ROWS;
`ifdef BOARD_ARB_HWM_EN
    localparam bit HWM_ON = 1'b1;
`else
    localparam bit HWM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       disp_req;
    logic [4:0] disp_x, disp_y;
    logic       disp_valid;
    logic [3:0] disp_kind;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_x, wr_y;
    logic [3:0] wr_kind;
    logic       clear_req;
    logic       clear_busy;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata = '0;
    logic [2:0] fifo_hwm;

    always #5 clk = ~clk;

    board_ram_arbiter #(.DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_valid(disp_valid), .disp_kind(disp_kind),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_kind(wr_kind),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_hwm(fifo_hwm)
    );

    // Single-port board RAM with one-cycle read latency.
    logic [3:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_en)      ram_rdata     <= mem[ram_addr];
    end

    typedef struct { int x; int y; int k; } wr_t;

    wr_t mq[$];
    int  rdq[$];
    int  ref_board [CELLS];
    bit  m_clear;
    int  m_cnt;
    int  m_hwm;
    bit  prev_rst = 1'b0;
    int  n_cmp = 0;
    int  n_bad = 0;

    bit  inr, push, ev;
    int  e_en, e_we, e_addr, e_data, dcell;
    wr_t w;

    initial for (int i = 0; i < CELLS; i++) ref_board[i] = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor/reference: sample mid-cycle, check outputs, advance the model.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_wr_ready", wr_ready, 0);
            if (prev_rst) begin
                chk("rst_disp_valid", disp_valid, 0);
                chk("rst_disp_kind", disp_kind, 0);
                chk("rst_clear_busy", clear_busy, 0);
                chk("rst_fifo_hwm", fifo_hwm, 0);
            end
            mq.delete();
            rdq.delete();
            m_clear = 1'b0;
            m_cnt   = 0;
            m_hwm   = 0;
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            ev = (rdq.size() > 0);
            chk("disp_valid", disp_valid, ev);
            if (ev) chk("disp_kind", disp_kind, rdq.pop_front());
            chk("clear_busy", clear_busy, m_clear);
            chk("wr_ready", wr_ready, mq.size() < DEPTH);
            chk("fifo_hwm", fifo_hwm, HWM_ON ? m_hwm : 0);

            inr  = disp_req && (disp_x < COLS) && (disp_y < ROWS);
            push = wr_valid && (mq.size() < DEPTH);
            e_en = 0; e_we = 0; e_addr = 0; e_data = 0;
            if (inr) begin
                dcell  = int'(disp_y) * COLS + int'(disp_x);
                e_en   = 1;
                e_addr = dcell;
            end
            if (disp_req) rdq.push_back(inr ? ref_board[dcell] : 0);

            if (m_clear) begin
                if (!inr) begin
                    e_en = 1; e_we = 1; e_addr = m_cnt; e_data = 0;
                    ref_board[m_cnt] = 0;
                    m_cnt++;
                    if (m_cnt == CELLS) m_clear = 1'b0;
                end
            end else if (clear_req) begin
                mq.delete();
                m_clear = 1'b1;
                m_cnt   = 0;
            end else if (!inr && mq.size() > 0) begin
                w = mq.pop_front();
                if (w.x < COLS && w.y < ROWS) begin
                    e_en = 1; e_we = 1;
                    e_addr = w.y * COLS + w.x;
                    e_data = w.k;
                    ref_board[e_addr] = w.k;
                end
            end

            chk("ram_en", ram_en, e_en);
            chk("ram_we", ram_we, e_we);
            if (e_en != 0) chk("ram_addr", ram_addr, e_addr);
            if (e_we != 0) chk("ram_wdata", ram_wdata, e_data);

            if (push) begin
                w.x = int'(wr_x); w.y = int'(wr_y); w.k = int'(wr_kind);
                mq.push_back(w);
                if (mq.size() > m_hwm) m_hwm = mq.size();
            end
        end
    end

    task automatic drive(input bit dr, input int dx, input int dy,
                         input bit wv, input int wx, input int wy, input int wk,
                         input bit cr);
        @(posedge clk); #1;
        disp_req  = dr;
        disp_x    = 5'(dx);
        disp_y    = 5'(dy);
        wr_valid  = wv;
        wr_x      = 5'(wx);
        wr_y      = 5'(wy);
        wr_kind   = 4'(wk);
        clear_req = cr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        disp_req = 0; disp_x = 0; disp_y = 0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_kind = 0; clear_req = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Display saturates the RAM; writes queue until the FIFO is full.
        for (int i = 0; i < 400; i++)
            drive(1, $urandom % COLS, $urandom % ROWS,
                  i < 6, $urandom % COLS, $urandom % ROWS, $urandom % 16, 0);
        idle(10);

        // Single write with display idle, then read it back.
        drive(0, 0, 0, 1, 3, 5, 7, 0);
        idle(3);
        drive(1, 3, 5, 0, 0, 0, 0, 0);
        idle(2);

        // Same-address ordering and an out-of-range write.
        drive(0, 0, 0, 1, 0, 0, 2, 0);
        drive(0, 0, 0, 1, 0, 0, 6, 0);
        drive(0, 0, 0, 1, 12, 0, 9, 0);
        idle(3);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Clear with two pending writes and a same-cycle write that survives.
        drive(1, 2, 2, 1, 4, 4, 3, 0);
        drive(1, 2, 3, 1, 5, 5, 8, 0);
        drive(1, 2, 4, 1, 1, 1, 4, 1);
        idle(205);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        drive(1, 4, 4, 0, 0, 0, 0, 0);
        drive(1, 5, 5, 0, 0, 0, 0, 0);
        idle(2);

        // Out-of-range display read frees the slot for the FIFO head.
        drive(1, 0, 0, 1, 7, 7, 5, 0);
        drive(1, 10, 3, 0, 0, 0, 0, 0);
        idle(2);
        drive(1, 7, 7, 0, 0, 0, 0, 0);
        idle(2);

        // Reset in the middle of a sweep.
        drive(0, 0, 0, 1, 2, 2, 9, 0);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        idle(20);
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(3);

        // Randomized traffic with occasional clears and wild coordinates.
        for (int i = 0; i < 3000; i++)
            drive($urandom % 2,
                  ($urandom % 16 == 0) ? $urandom % 32 : $urandom % COLS,
                  ($urandom % 16 == 0) ? $urandom % 32 : $urandom % ROWS,
                  ($urandom % 3) != 0,
                  ($urandom % 12 == 0) ? $urandom % 32 : $urandom % COLS,
                  ($urandom % 12 == 0) ? $urandom % 32 : $urandom % ROWS,
                  $urandom % 16,
                  ($urandom % 400) == 0);
        idle(300);

        // Read back the whole board.
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                drive(1, x, y, 0, 0, 0, 0, 0);
        idle(3);

        chk("scoreboard_drained", rdq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
